// File: rtl/cap_pkg.sv
// Shared types and default sizes for the logic-analyser capture engine.
package cap_pkg;

    localparam int CAP_CH_W_DEFAULT  = 8;
    localparam int CAP_DEPTH_DEFAULT = 8192;
    localparam int CAP_DIV_W_DEFAULT = 24;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        POST      = 2'd2,
        READOUT   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/cap_if.sv
// Readout stream of the capture engine: valid/ready handshake carrying one sample per transfer.
interface cap_if import cap_pkg::*; #(
    parameter int CH_W = CAP_CH_W_DEFAULT
) ();

    logic [CH_W-1:0] rd_data;
    logic            rd_valid;
    logic            rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface

// File: rtl/cap_ram.sv
// Simple dual-port sample memory: one write port, one registered read port (maps onto iCE40 BRAM).
module cap_ram import cap_pkg::*; #(
    parameter int  W     = CAP_CH_W_DEFAULT,
    parameter int  DEPTH = CAP_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; no reset so the array stays a plain block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port with one cycle of latency; output holds while re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cap_engine.sv
// Capture engine: samples CAP at a programmable rate into a ring buffer, waits for a masked
// trigger, records a post-trigger window and then streams the buffer out newest-first.
module cap_engine import cap_pkg::*; #(
    parameter int  CH_W  = CAP_CH_W_DEFAULT,
    parameter int  DEPTH = CAP_DEPTH_DEFAULT,
    parameter int  DIV_W = CAP_DIV_W_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CAP_CLK,
    input  logic             RST,
    input  logic [CH_W-1:0]  CAP,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CH_W-1:0]  cfg_mask,
    input  logic [CH_W-1:0]  cfg_value,
    input  logic [AW:0]      cfg_delay,
    input  logic             arm,
    input  logic             abort,
    cap_if.master            rd,
    output logic             busy,
    output logic             triggered,
    output logic             done
);

    localparam logic [AW:0] DEPTH_V  = DEPTH[AW:0];
    localparam logic [AW:0] POST_ONE = {{AW{1'b0}}, 1'b1};

    cap_state_t       state;
    logic [CH_W-1:0]  cap_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt;
    logic [CH_W-1:0]  mask_q;
    logic [CH_W-1:0]  value_q;
    logic [AW:0]      delay_q;
    logic [AW-1:0]    wr_addr;
    logic [AW:0]      fill;
    logic [AW:0]      post_cnt;
    logic [AW-1:0]    rd_addr;
    logic [AW:0]      issue_cnt;
    logic             ram_vld;
    logic [CH_W-1:0]  ram_q;

    logic             capturing;
    logic             strobe;
    logic             trig_hit;
    logic [AW:0]      fill_next;
    logic [AW:0]      post_load;
    logic             enter_ro;
    logic             in_readout;
    logic             out_free;
    logic             move;
    logic             issue;
    logic             last_xfer;

    assign busy = (state != IDLE);

    // Sample strobe, trigger match and readout pipeline steering
    always_comb begin
        capturing  = (state == WAIT_TRIG) || (state == POST);
        strobe     = capturing && (div_cnt == div_q) && !abort;
        trig_hit   = strobe && (state == WAIT_TRIG) && (((cap_q ^ value_q) & mask_q) == '0);
        fill_next  = (fill == DEPTH_V) ? fill : fill + 1'b1;
        post_load  = (delay_q == '0) ? '0 : delay_q - 1'b1;
        enter_ro   = (trig_hit && (post_load == '0))
                   || (strobe && (state == POST) && (post_cnt == POST_ONE));
        in_readout = (state == READOUT);
        out_free   = !rd.rd_valid || rd.rd_ready;
        move       = in_readout && ram_vld && out_free;
        issue      = in_readout && (issue_cnt != '0) && (!ram_vld || move);
        last_xfer  = in_readout && rd.rd_valid && rd.rd_ready && !ram_vld && (issue_cnt == '0);
    end

    // Single input register shared by the trigger compare and the memory write
    always_ff @(posedge CAP_CLK or posedge RST) begin
        if (RST) begin
            cap_q <= '0;
        end else begin
            cap_q <= CAP;
        end
    end

    // Sequencer: arm/capture/post-trigger/readout with abort overriding everything
    always_ff @(posedge CAP_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            div_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            delay_q     <= '0;
            div_cnt     <= '0;
            wr_addr     <= '0;
            fill        <= '0;
            post_cnt    <= '0;
            rd_addr     <= '0;
            issue_cnt   <= '0;
            ram_vld     <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            div_cnt     <= '0;
            issue_cnt   <= '0;
            ram_vld     <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        div_q     <= cfg_div;
                        mask_q    <= cfg_mask;
                        value_q   <= cfg_value;
                        delay_q   <= (cfg_delay > DEPTH_V) ? DEPTH_V : cfg_delay;
                        div_cnt   <= '0;
                        wr_addr   <= '0;
                        fill      <= '0;
                        triggered <= 1'b0;
                        state     <= WAIT_TRIG;
                    end
                end

                WAIT_TRIG, POST: begin
                    if (strobe) begin
                        div_cnt <= '0;
                        wr_addr <= wr_addr + 1'b1;
                        fill    <= fill_next;
                        if (trig_hit) begin
                            triggered <= 1'b1;
                            post_cnt  <= post_load;
                        end else if (state == POST) begin
                            post_cnt <= post_cnt - 1'b1;
                        end
                        if (enter_ro) begin
                            // The sample just written sits at wr_addr, so that is the newest
                            state       <= READOUT;
                            done        <= 1'b1;
                            rd_addr     <= wr_addr;
                            issue_cnt   <= fill_next;
                            ram_vld     <= 1'b0;
                            rd.rd_valid <= 1'b0;
                        end else if (trig_hit) begin
                            state <= POST;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                READOUT: begin
                    if (move) begin
                        rd.rd_data  <= ram_q;
                        rd.rd_valid <= 1'b1;
                    end else if (rd.rd_ready) begin
                        rd.rd_valid <= 1'b0;
                    end
                    if (issue) begin
                        rd_addr   <= rd_addr - 1'b1;
                        issue_cnt <= issue_cnt - 1'b1;
                        ram_vld   <= 1'b1;
                    end else if (move) begin
                        ram_vld <= 1'b0;
                    end
                    if (last_xfer) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    cap_ram #(
        .W     (CH_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CAP_CLK),
        .we    (strobe),
        .waddr (wr_addr),
        .wdata (cap_q),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_cap_engine.sv
// Scoreboard bench for cap_engine: directed captures, expected samples queued before each run.
module tb_cap_engine;

    localparam int CH_W  = 8;
    localparam int DEPTH = 16;
    localparam int DIV_W = 24;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic [CH_W-1:0]  cap;
    logic [DIV_W-1:0] cfg_div;
    logic [CH_W-1:0]  cfg_mask;
    logic [CH_W-1:0]  cfg_value;
    logic [AW:0]      cfg_delay;
    logic             arm;
    logic             abort;
    logic             busy;
    logic             triggered;
    logic             done;

    cap_if #(.CH_W(CH_W)) rd_if ();

    cap_engine #(
        .CH_W  (CH_W),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .CAP_CLK   (clk),
        .RST       (rst),
        .CAP       (cap),
        .cfg_div   (cfg_div),
        .cfg_mask  (cfg_mask),
        .cfg_value (cfg_value),
        .cfg_delay (cfg_delay),
        .arm       (arm),
        .abort     (abort),
        .rd        (rd_if.master),
        .busy      (busy),
        .triggered (triggered),
        .done      (done)
    );

    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cap_idx  = 0;
    int         pat_mode = 0;
    bit         rand_ready = 0;
    bit         stall_pend = 0;
    logic [7:0] stall_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Channel pattern: mode 0 counts, mode 1 keeps bit7 low for the first 40 samples
    function automatic logic [7:0] pattern(input int idx);
        logic [31:0] v;
        v = idx;
        if (pat_mode == 0) return v[7:0];
        return {(v >= 32'd40), v[6:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: advance the channel pattern and optionally randomise rd_ready
    task automatic tick();
        @(posedge clk);
        #1;
        cap_idx++;
        cap = pattern(cap_idx);
        if (rand_ready) rd_if.rd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_stimulus(input logic [DIV_W-1:0] div, input logic [7:0] mask,
                                  input logic [7:0] value, input logic [AW:0] delay);
        cfg_div   = div;
        cfg_mask  = mask;
        cfg_value = value;
        cfg_delay = delay;
        cap_idx   = 0;
        cap       = pattern(0);
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_output("done_rise", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_output("busy_fall", 32'(busy), 32'd0);
        check_output("done_fall", 32'(done), 32'd0);
        check_output("valid_fall", 32'(rd_if.rd_valid), 32'd0);
        check_output("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_trig"}, 32'(triggered), 32'd0);
        check_output({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd0);
        check_output({tag, "_data"}, 32'(rd_if.rd_data), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stalled data holds
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && rd_if.rd_valid) begin
                if (stall_pend) check_output("stall_hold", 32'(rd_if.rd_data), 32'(stall_data));
                if (rd_if.rd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_sample: got %0h with no sample expected", rd_if.rd_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check_output("rd_data", 32'(rd_if.rd_data), 32'(exp));
                    end
                    stall_pend = 1'b0;
                end else begin
                    stall_pend = 1'b1;
                    stall_data = rd_if.rd_data;
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // Hard time limit so the bench always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; cap = '0;
        cfg_div = '0; cfg_mask = '0; cfg_value = '0; cfg_delay = '0;
        rd_if.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        tick();

        $display("[TB] basic capture: div=0 mask=0 delay=4");
        rd_if.rd_ready = 1'b1;
        for (int v = 3; v >= 0; v--) exp_q.push_back(8'(v));
        apply_stimulus('0, 8'h00, 8'h00, 5'd4);
        check_output("busy_after_arm", 32'(busy), 32'd1);
        wait_done(50);
        check_output("triggered_basic", 32'(triggered), 32'd1);
        wait_idle(50);

        $display("[TB] bit7 trigger with ring wrap: delay=8");
        pat_mode = 1;
        for (int n = 47; n >= 32; n--) exp_q.push_back(pattern(n));
        apply_stimulus('0, 8'h80, 8'h80, 5'd8);
        wait_done(200);
        check_output("triggered_bit7", 32'(triggered), 32'd1);
        wait_idle(100);
        pat_mode = 0;

        $display("[TB] divider: div=2 delay=3");
        exp_q.push_back(8'd8); exp_q.push_back(8'd5); exp_q.push_back(8'd2);
        apply_stimulus(24'd2, 8'h00, 8'h00, 5'd3);
        wait_done(100);
        wait_idle(100);

        $display("[TB] random rd_ready: delay=10");
        for (int v = 9; v >= 0; v--) exp_q.push_back(8'(v));
        rand_ready = 1'b1;
        apply_stimulus('0, 8'h00, 8'h00, 5'd10);
        wait_done(100);
        wait_idle(500);
        rand_ready = 1'b0;
        rd_if.rd_ready = 1'b1;

        $display("[TB] abort during POST");
        apply_stimulus('0, 8'h00, 8'h00, 5'd8);
        tick();
        tick();
        check_output("post_trig", 32'(triggered), 32'd1);
        check_output("post_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_quiet("abort");
        tick();
        check_output("abort_stays_idle", 32'(busy), 32'd0);

        $display("[TB] reset during READOUT");
        rd_if.rd_ready = 1'b0;
        apply_stimulus('0, 8'h00, 8'h00, 5'd4);
        wait_done(50);
        tick();
        tick();
        check_output("prefetch_valid", 32'(rd_if.rd_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_quiet("midrst");
        rst = 1'b0;
        tick();
        rd_if.rd_ready = 1'b1;
        for (int v = 3; v >= 0; v--) exp_q.push_back(8'(v));
        apply_stimulus('0, 8'h00, 8'h00, 5'd4);
        wait_done(50);
        wait_idle(50);

        $display("[TB] delay=0 gives one sample");
        exp_q.push_back(8'd0);
        apply_stimulus('0, 8'h00, 8'h00, 5'd0);
        wait_done(50);
        wait_idle(50);

        $display("[TB] delay=DEPTH+5 clamps to DEPTH");
        for (int v = 15; v >= 0; v--) exp_q.push_back(8'(v));
        apply_stimulus('0, 8'h00, 8'h00, 5'd21);
        wait_done(100);
        wait_idle(100);

        $display("[TB] arm and cfg changes while busy are ignored");
        for (int v = 3; v >= 0; v--) exp_q.push_back(8'(v));
        apply_stimulus('0, 8'h00, 8'h00, 5'd4);
        cfg_div   = 24'd5;
        cfg_mask  = 8'hFF;
        cfg_value = 8'h55;
        cfg_delay = 5'd1;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
        check_output("rearm_busy", 32'(busy), 32'd1);
        wait_done(50);
        wait_idle(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
